fifo_async_rd_stream: RTL and testbench



---
 rtl/fifo_async_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_async_rd_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_rd_stream.sv
// fifo_async_rd_stream
// Read-side adapter for the async FIFO, living entirely in the read-clock domain.
// It issues FIFO reads only when a buffer slot is guaranteed for the returning
// beat. That credit check is what turns the FIFO's non-stallable 1-cycle read
// data into a valid/ready stream with full backpressure.
module fifo_async_rd_stream #(
    parameter int BITWIDTH  = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FIFO_EMPTY,
    output logic                       FIFO_R_EN,
    input  logic [BITWIDTH-1:0]        FIFO_DATA,
    input  logic                       FIFO_DATA_VALID,
    output logic [BITWIDTH-1:0]        M_DATA,
    output logic                       M_VALID,
    input  logic                       M_READY,
    output logic [$clog2(BUF_DEPTH):0] BUF_LEVEL,
    output logic                       ERR
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(BUF_DEPTH);

    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                inflight_q, inflight_d;
    logic                err_q, err_d;
    logic [BITWIDTH-1:0] mem_q [BUF_DEPTH];

    logic                req;
    logic                pop;
    logic                push;
    logic [SUM_W-1:0]    creditSum;

    // Stream outputs come straight from registered state, so there is no path from FIFO_DATA
    always_comb begin
        M_VALID   = (count_q != '0);
        M_DATA    = M_VALID ? mem_q[rdPtr_q] : '0;
        BUF_LEVEL = count_q;
        ERR       = err_q;
    end

    // Handshakes plus the credit check: a read may issue only if its data is certain to find a free slot
    always_comb begin
        pop       = M_VALID && M_READY;
        push      = FIFO_DATA_VALID && inflight_q;
        creditSum = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(pop);
        FIFO_R_EN = !RST && !FIFO_EMPTY && (creditSum < DEPTH_SUM);
        req       = FIFO_R_EN && !FIFO_EMPTY;
    end

    // Next-state for pointers, occupancy, outstanding-read flag and sticky error
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        inflight_d = req;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d      = err_q || (FIFO_DATA_VALID && !inflight_q);
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
    end

    // Control state register; reset drops buffered and in-flight beats
    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Buffer storage is left unreset; only the pointers and count decide what is valid
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wrPtr_q] <= FIFO_DATA;
        end
    end

    // The credit rule must prevent a push into a full buffer
    assert property (@(posedge CLK) disable iff (RST) !(push && count_q == DEPTH_CNT && !pop));

endmodule

// File: tb/tb_fifo_async_rd_stream.sv
// tb_fifo_async_rd_stream
// Directed bench driving a depth-4 and a depth-2 instance from a small
// behavioural FIFO model with a 1-cycle read latency. Delivered beats are
// compared against an incrementing expected sequence.
module tb_fifo_async_rd_stream;

    logic        CLK;
    logic        RST;

    logic        fifoEmpty, fifoREn, fifoDataValid, mValid, mReady, err;
    logic [31:0] fifoData, mData;
    logic [2:0]  bufLevel;

    logic        fifoEmpty2, fifoREn2, fifoDataValid2, mValid2, mReady2, err2;
    logic [31:0] fifoData2, mData2;
    logic [1:0]  bufLevel2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] src1, exp1, src2, exp2, firstBeat;
    int          popCount1, popCount2, reqCount1, maxLevel1, badREn;

    fifo_async_rd_stream #(.BITWIDTH(32), .BUF_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .FIFO_EMPTY(fifoEmpty), .FIFO_R_EN(fifoREn),
        .FIFO_DATA(fifoData), .FIFO_DATA_VALID(fifoDataValid),
        .M_DATA(mData), .M_VALID(mValid), .M_READY(mReady),
        .BUF_LEVEL(bufLevel), .ERR(err)
    );

    fifo_async_rd_stream #(.BITWIDTH(32), .BUF_DEPTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .FIFO_EMPTY(fifoEmpty2), .FIFO_R_EN(fifoREn2),
        .FIFO_DATA(fifoData2), .FIFO_DATA_VALID(fifoDataValid2),
        .M_DATA(mData2), .M_VALID(mValid2), .M_READY(mReady2),
        .BUF_LEVEL(bufLevel2), .ERR(err2)
    );

    // Free-running read clock, period 10
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, then update the FIFO model after the rising edge
    task automatic applyStimulus();
        logic req1, req2;
        #4;
        req1 = fifoREn && !fifoEmpty;
        req2 = fifoREn2 && !fifoEmpty2;
        if (req1) reqCount1++;
        if (fifoREn && fifoEmpty) badREn++;
        if (int'(bufLevel) > maxLevel1) maxLevel1 = int'(bufLevel);
        if (mValid && mReady) begin
            checkOutput("beat_d4", mData, exp1);
            exp1++;
            popCount1++;
        end
        if (mValid2 && mReady2) begin
            checkOutput("beat_d2", mData2, exp2);
            exp2++;
            popCount2++;
        end
        @(posedge CLK);
        #1;
        fifoDataValid = req1;
        if (req1) begin
            fifoData = src1;
            src1++;
        end
        fifoDataValid2 = req2;
        if (req2) begin
            fifoData2 = src2;
            src2++;
        end
    endtask

    // Directed sequence
    initial begin
        RST = 1'b1;
        fifoEmpty = 1'b1; fifoDataValid = 1'b0; fifoData = '0; mReady = 1'b0;
        fifoEmpty2 = 1'b1; fifoDataValid2 = 1'b0; fifoData2 = '0; mReady2 = 1'b0;
        src1 = 32'hA0; exp1 = 32'hA0; src2 = 32'hB0; exp2 = 32'hB0;
        popCount1 = 0; popCount2 = 0; reqCount1 = 0; maxLevel1 = 0; badREn = 0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        checkOutput("rst_m_valid", mValid, 1'b0);
        checkOutput("rst_m_data", mData, 32'h0);
        checkOutput("rst_level", bufLevel, 3'd0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_r_en", fifoREn, 1'b0);

        // Streaming with ready high: read at cycle 0, first beat at cycle 2
        RST = 1'b0; fifoEmpty = 1'b0; mReady = 1'b1;
        #1;
        checkOutput("c0_r_en", fifoREn, 1'b1);
        applyStimulus();
        checkOutput("c1_m_valid", mValid, 1'b0);
        applyStimulus();
        checkOutput("c2_m_valid", mValid, 1'b1);
        checkOutput("c2_m_data", mData, 32'hA0);
        popCount1 = 0; maxLevel1 = 0;
        repeat (20) applyStimulus();
        checkOutput("stream_beats", popCount1, 20);
        checkOutput("stream_level_le2", maxLevel1 <= 2, 1'b1);

        // Drain, then backpressure with the FIFO always non-empty
        fifoEmpty = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("drain_level", bufLevel, 3'd0);
        fifoEmpty = 1'b0; mReady = 1'b0; reqCount1 = 0; firstBeat = exp1;
        repeat (10) applyStimulus();
        checkOutput("bp_reads", reqCount1, 4);
        checkOutput("bp_level", bufLevel, 3'd4);
        checkOutput("bp_r_en", fifoREn, 1'b0);
        checkOutput("bp_m_valid", mValid, 1'b1);
        checkOutput("bp_m_data_held", mData, firstBeat);
        mReady = 1'b1; popCount1 = 0;
        repeat (12) applyStimulus();
        checkOutput("bp_release_beats", popCount1, 12);

        // Random ready and empty for 1000 beats
        popCount1 = 0; maxLevel1 = 0;
        for (int c = 0; c < 20000 && popCount1 < 1000; c++) begin
            fifoEmpty = ($urandom_range(0, 3) == 0);
            mReady = $urandom_range(0, 1) != 0;
            applyStimulus();
        end
        checkOutput("rand_beats", popCount1, 1000);
        checkOutput("rand_err", err, 1'b0);
        checkOutput("rand_level_le4", maxLevel1 <= 4, 1'b1);
        fifoEmpty = 1'b1; mReady = 1'b1;
        repeat (6) applyStimulus();
        checkOutput("rand_drain_level", bufLevel, 3'd0);

        // Empty flag toggling every cycle
        reqCount1 = 0; popCount1 = 0; badREn = 0;
        for (int c = 0; c < 20; c++) begin
            fifoEmpty = (c % 2 == 1);
            applyStimulus();
        end
        fifoEmpty = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("tog_reads", reqCount1, 10);
        checkOutput("tog_beats", popCount1, 10);
        checkOutput("tog_r_en_when_empty", badREn, 0);

        // Unrequested data: dropped and flagged until reset
        fifoDataValid = 1'b1; fifoData = 32'hDEAD;
        applyStimulus();
        checkOutput("inj_err", err, 1'b1);
        checkOutput("inj_m_valid", mValid, 1'b0);
        checkOutput("inj_level", bufLevel, 3'd0);
        repeat (5) applyStimulus();
        checkOutput("inj_err_held", err, 1'b1);
        checkOutput("inj_m_valid_held", mValid, 1'b0);
        RST = 1'b1;
        applyStimulus();
        checkOutput("inj_err_cleared", err, 1'b0);
        RST = 1'b0;

        // Depth-2 instance: full throughput, then reset mid-stream
        fifoEmpty2 = 1'b0; mReady2 = 1'b1;
        #1;
        checkOutput("d2_c0_r_en", fifoREn2, 1'b1);
        applyStimulus();
        checkOutput("d2_c1_m_valid", mValid2, 1'b0);
        applyStimulus();
        checkOutput("d2_c2_m_valid", mValid2, 1'b1);
        checkOutput("d2_c2_m_data", mData2, 32'hB0);
        popCount2 = 0;
        repeat (10) applyStimulus();
        checkOutput("d2_beats", popCount2, 10);
        checkOutput("d2_level", bufLevel2, 2'd1);
        RST = 1'b1;
        applyStimulus();
        checkOutput("d2_rst_m_valid", mValid2, 1'b0);
        checkOutput("d2_rst_level", bufLevel2, 2'd0);
        checkOutput("d2_rst_r_en", fifoREn2, 1'b0);
        RST = 1'b0; fifoEmpty2 = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("d2_post_rst_err", err2, 1'b0);
        checkOutput("d2_post_rst_level", bufLevel2, 2'd0);
        exp2 = src2; fifoEmpty2 = 1'b0; popCount2 = 0;
        repeat (6) applyStimulus();
        checkOutput("d2_restart_beats", popCount2, 4);
        checkOutput("d2_restart_err", err2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
